// File: rtl/gpi_debounce_pkg.sv
// gpi_debounce_pkg: shared state type and default constants for the GPI debouncer.
package gpi_debounce_pkg;
  typedef enum logic {DbStable, DbPending} db_state_e;
  localparam int GpiWidthDefault = 8;
  localparam int SyncStagesDefault = 2;
  localparam int DebounceCyclesDefault = 500_000;
endpackage

// File: rtl/gpi_debounce_bit.sv
// gpi_debounce_bit: one channel - synchroniser, debounce counter, level flop and edge pulses.
module gpi_debounce_bit
  import gpi_debounce_pkg::*;
#(
  parameter int SyncStages = SyncStagesDefault,
  parameter int DebounceCycles = DebounceCyclesDefault,
  parameter int CntWidth = $clog2(DebounceCycles + 1)
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic pad_i,
  output logic gp_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SyncStages-1:0] r_sync;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_cnt_nxt;
  logic r_level;
  logic r_rise;
  logic r_fall;
  logic w_sync;
  logic w_accept;
  db_state_e w_state;
  assign w_sync = r_sync[SyncStages-1];
  // The state is fully determined by whether the synchronised input disagrees with the accepted level.
  always_comb begin
    w_state = (w_sync != r_level) ? DbPending : DbStable;
    w_accept = (w_state == DbPending) && (r_cnt == CntWidth'(DebounceCycles - 1));
    w_cnt_nxt = (w_state == DbPending && !w_accept) ? r_cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_level <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], pad_i};
      r_cnt <= w_cnt_nxt;
      r_level <= w_accept ? w_sync : r_level;
      r_rise <= w_accept & w_sync;
      r_fall <= w_accept & ~w_sync;
    end
  end
  assign gp_o = r_level;
  assign rise_o = r_rise;
  assign fall_o = r_fall;
endmodule

// File: rtl/gpi_debounce.sv
// gpi_debounce: per-bit synchronise and debounce of raw pads into gp_i levels plus edge pulses.
// Optional sticky edge interrupt enabled by defining GPI_DEBOUNCE_IRQ_EN.
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int GpiWidth = GpiWidthDefault,
  parameter int SyncStages = SyncStagesDefault,
  parameter int DebounceCycles = DebounceCyclesDefault
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_ni,
  input  logic [GpiWidth-1:0] pad_i,
`ifdef GPI_DEBOUNCE_IRQ_EN
  input  logic [GpiWidth-1:0] irq_clear_i,
  output logic [GpiWidth-1:0] irq_pending_o,
  output logic                irq_o,
`endif
  output logic [GpiWidth-1:0] gp_o,
  output logic [GpiWidth-1:0] rise_o,
  output logic [GpiWidth-1:0] fall_o
);
  localparam int CntWidth = $clog2(DebounceCycles + 1);
  for (genvar i = 0; i < GpiWidth; i++) begin : g_bit
    gpi_debounce_bit #(
      .SyncStages(SyncStages),
      .DebounceCycles(DebounceCycles),
      .CntWidth(CntWidth)
    ) u_bit (
      .clk_sys_i(clk_sys_i),
      .rst_sys_ni(rst_sys_ni),
      .pad_i(pad_i[i]),
      .gp_o(gp_o[i]),
      .rise_o(rise_o[i]),
      .fall_o(fall_o[i])
    );
  end
`ifdef GPI_DEBOUNCE_IRQ_EN
  logic [GpiWidth-1:0] r_pending;
  // A new event outranks a clear landing in the same cycle.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) r_pending <= '0;
    else r_pending <= (r_pending & ~irq_clear_i) | rise_o | fall_o;
  end
  assign irq_pending_o = r_pending;
  assign irq_o = |r_pending;
`endif
endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Board-level input conditioning stage that sits directly upstream of ibex_demo_system's gp_i port.
- Takes raw, asynchronous switch and button pads from the Arty S7 and synchronises each bit into the system clock domain.
- Debounces each bit independently.
- Presents a clean level vector plus one-cycle rise and fall event pulses to the system GPIO input.

Parameters:
GpiWidth, 8, number of input bits; matches system GpiWidth
SyncStages, 2, flip-flops in each bit's synchroniser chain; legal range 2..4
DebounceCycles, 500_000, number of consecutive cycles the synchronised value must differ from the debounced value before it is accepted (10 ms at 50 MHz); must be >= 1
CntWidth, $clog2(DebounceCycles+1), derived width of the per-bit counter; not overridden by users

Ports:
clk_sys_i  input  1  system clock
rst_sys_ni  input  1  asynchronous, active-low reset
pad_i  input  GpiWidth  raw asynchronous pad levels
gp_o  output  GpiWidth  debounced levels; connects to ibex_demo_system gp_i
rise_o  output  GpiWidth  one-cycle pulse when the matching gp_o bit goes 0->1
fall_o  output  GpiWidth  one-cycle pulse when the matching gp_o bit goes 1->0

Behaviour:
- Clock and reset: one clock, clk_sys_i. Reset is asynchronous, active-low, on rst_sys_ni. Every flop below resets asynchronously.
- Reset values: all synchroniser flops 0, all counters 0, gp_o 0, rise_o 0, fall_o 0.
- Synchroniser: pad_i[i] passes through SyncStages flops; sync[i] is the last stage. No other logic touches pad_i.
- Per-bit state machine, two states:
  - STABLE (sync[i] == gp_o[i]): counter held at 0.
  - PENDING (sync[i] != gp_o[i]): counter increments by 1 each cycle.
- Acceptance: in PENDING with counter == DebounceCycles-1, on the next clock edge:
  - gp_o[i] takes sync[i];
  - counter clears;
  - rise_o[i] or fall_o[i] asserts for exactly that one cycle.
- Glitch rejection: if sync[i] returns to gp_o[i] before acceptance, counter clears to 0 on the next edge and no event is produced. A new mismatch restarts the count from 0.
- Latency: a clean pad step reaches gp_o in SyncStages + DebounceCycles cycles. Events align with the gp_o change, never before or after it.
- DebounceCycles == 1: gp_o follows sync with 1 cycle of delay, and every change produces an event.
- Counter overflow: counter never exceeds DebounceCycles-1; no wrap-around is possible.
- Simultaneous changes: bits are fully independent. Several bits may accept, and several events may assert, in the same cycle.
- Mid-operation reset: asserting rst_sys_ni discards all pending counts. After release, any pad held at 1 reaches gp_o after the full latency and produces a rise pulse.
- rise_o[i] and fall_o[i] are never high in the same cycle.

Optional Feature:
Macro: GPI_DEBOUNCE_IRQ_EN.
- With the macro defined, the block adds these ports:
  - irq_clear_i  input  GpiWidth: write-1-to-clear strobe.
  - irq_pending_o  output  GpiWidth: sticky pending bits.
  - irq_o  output  1: equals the OR of irq_pending_o.
- pending[i] sets on rise_o[i] or fall_o[i] and clears on irq_clear_i[i].
- If set and clear occur in the same cycle, set wins.
- irq_pending_o and irq_o reset to 0.
- irq_o is registered output of the pending flops, so it rises 1 cycle after the event pulse.
- Without the macro: these ports and their flops do not exist, and block behaviour is otherwise identical.

Decomposition:
- Package gpi_debounce_pkg holds:
  - typedef enum logic {DbStable, DbPending} db_state_e;
  - default constants GpiWidthDefault = 8, SyncStagesDefault = 2, DebounceCyclesDefault = 500_000.
- Sub-module gpi_debounce_bit implements one channel: synchroniser, counter, level flop and edge detection.
- The top module instantiates GpiWidth copies with a generate loop, and adds the optional IRQ logic at top level.

Test Plan (bench parameters: GpiWidth=4, SyncStages=2, DebounceCycles=4):
1. Reset, then pad_i 4'b0000 -> 4'b0001 held: gp_o becomes 4'b0001 exactly 6 cycles after the pad edge; rise_o = 4'b0001 for 1 cycle in that same cycle; fall_o stays 0.
2. pad_i[1] pulses high for 3 cycles then low: gp_o[1] stays 0, and rise_o and fall_o stay 0 throughout.
3. pad_i[2] bounces 1,0,1,1,1,1 (one cycle each), then holds 1: counter restarts after the 0; gp_o[2] rises 6 cycles after the final 0->1 transition.
4. pad_i 4'b1111 -> 4'b0000 at once from the stable-1 state: gp_o becomes 0000 after 6 cycles and fall_o = 4'b1111 for 1 cycle.
5. Reset asserted 2 cycles into a pending count with pad_i = 4'b1000, then released and pad held: gp_o = 0 during reset; gp_o[3] rises 6 cycles after release with one rise pulse.
6. With GPI_DEBOUNCE_IRQ_EN defined:
   - Rise event on bit 0: irq_pending_o = 4'b0001 and irq_o = 1 one cycle after rise_o.
   - irq_clear_i = 4'b0001 issued in the same cycle as a new fall event on bit 0: pending stays 1.
   - irq_clear_i = 4'b0001 the following cycle: pending clears to 0, and irq_o falls.
